// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - store-port request/response types, requester indices and arbiter states
package ariane_pkg;

  localparam int NR_STORE_PORTS = 2;
  localparam int ST_PORT_SB     = 0;
  localparam int ST_PORT_AMO    = 1;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} st_arb_state_t;

  typedef struct packed {
    logic [11:0] address_index;
    logic [43:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/store_port_sel.sv
// rtl/store_port_sel.sv - combinational requester select, round-robin from ptr
// STORE_ARB_FIXED_PRIO_EN switches to fixed priority (index 0 wins) and ignores ptr
module store_port_sel #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               block_i,
  output logic [IDX_W-1:0]   sel,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef STORE_ARB_FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
`endif
      if (!found && req_vec[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_valid = found && !block_i;

`ifdef STORE_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/store_port_arbiter.sv
// rtl/store_port_arbiter.sv - locks the single D$ store port to one requester until granted
// STORE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin
module store_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             block_i,
  output logic             idle_o,
  input  dcache_req_i_t    req_port_i [NUM_REQ],
  output dcache_req_o_t    req_port_o [NUM_REQ],
  output dcache_req_i_t    dcache_req_o,
  input  dcache_req_o_t    dcache_req_i,
  output logic [IDX_W-1:0] grant_idx_o
);

  st_arb_state_t      state_q;
  logic [IDX_W-1:0]   idx_q, rsp_idx_q, ptr, sel, cur_idx;
  logic [NUM_REQ-1:0] req_vec;
  logic               any_valid, active, gnt;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) req_vec[i] = req_port_i[i].data_req;
  end

  store_port_sel #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_sel (
    .req_vec  (req_vec),
    .ptr      (ptr),
    .block_i  (block_i),
    .sel      (sel),
    .any_valid(any_valid)
  );

  // A locked requester keeps the port regardless of block_i or competing requests.
  assign cur_idx      = (state_q == ARB_LOCKED) ? idx_q : sel;
  assign active       = !rst_i && ((state_q == ARB_LOCKED) || any_valid);
  assign gnt          = active && dcache_req_i.data_gnt;
  assign dcache_req_o = active ? req_port_i[cur_idx] : '0;
  assign grant_idx_o  = active ? cur_idx : '0;
  assign idle_o       = (state_q == ARB_IDLE) && !dcache_req_o.data_req;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_port_o[i]          = '0;
      req_port_o[i].data_gnt = gnt && (cur_idx == IDX_W'(i));
      if (rsp_idx_q == IDX_W'(i)) begin
        req_port_o[i].data_rvalid = dcache_req_i.data_rvalid;
        req_port_o[i].data_rdata  = dcache_req_i.data_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      idx_q     <= '0;
      rsp_idx_q <= '0;
    end else if (gnt) begin
      state_q   <= ARB_IDLE;
      rsp_idx_q <= cur_idx;
    end else if (active && (state_q == ARB_IDLE)) begin
      state_q <= ARB_LOCKED;
      idx_q   <= sel;
    end
  end

`ifdef STORE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, nxt_ptr;

  assign ptr     = ptr_q;
  assign nxt_ptr = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i)    ptr_q <= '0;
    else if (gnt) ptr_q <= nxt_ptr;
  end
`endif

endmodule

// File: tb/tb_store_port_arbiter.sv
// tb/tb_store_port_arbiter.sv - directed and randomized checks of store_port_arbiter against a queue-level model
module tb_store_port_arbiter;
  import ariane_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;

  logic             clk_i = 1'b0;
  logic             rst_i, block_i, idle_o;
  dcache_req_i_t    req_port_i [NUM_REQ];
  dcache_req_o_t    req_port_o [NUM_REQ];
  dcache_req_i_t    dcache_req_o;
  dcache_req_o_t    dcache_req_i;
  logic [IDX_W-1:0] grant_idx_o;

  store_port_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .block_i     (block_i),
    .idle_o      (idle_o),
    .req_port_i  (req_port_i),
    .req_port_o  (req_port_o),
    .dcache_req_o(dcache_req_o),
    .dcache_req_i(dcache_req_i),
    .grant_idx_o (grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: owner = requester holding the port (-1 none), ptr = round-robin start, last = last granted
  int owner = -1;
  int ptr   = 0;
  int last  = 0;

  bit            rq [NUM_REQ];
  dcache_req_i_t pl [NUM_REQ];
  bit            d_rst, d_block, d_gnt, d_rvalid, hold_all;
  logic [63:0]   d_rdata;

  logic             obs_dreq, obs_idle;
  logic [IDX_W-1:0] obs_gidx;
  logic             obs_gnt [NUM_REQ];
  logic             obs_rv  [NUM_REQ];
  logic [63:0]      obs_rd  [NUM_REQ];

  function automatic dcache_req_i_t rnd_pl();
    dcache_req_i_t p;
    p.address_index = 12'($urandom);
    p.address_tag   = 44'({$urandom, $urandom});
    p.data_wdata    = {$urandom, $urandom};
    p.data_req      = 1'b0;
    p.data_we       = 1'b1;
    p.data_be       = 8'($urandom);
    p.data_size     = 2'($urandom);
    return p;
  endfunction

  function automatic int model_pick();
    int c;
    if (d_rst) return -1;
    if (owner >= 0) return owner;
    if (d_block) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef STORE_ARB_FIXED_PRIO_EN
      c = k;
`else
      c = (ptr + k) % NUM_REQ;
`endif
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input bit chk);
    int p;
    dcache_req_i_t exp_req;
    @(negedge clk_i);
    rst_i   = d_rst;
    block_i = d_block;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_port_i[i]          = pl[i];
      req_port_i[i].data_req = rq[i];
    end
    p = model_pick();
    dcache_req_i.data_gnt    = d_gnt && (p >= 0);
    dcache_req_i.data_rvalid = d_rvalid;
    dcache_req_i.data_rdata  = d_rdata;
    #1;
    obs_dreq = dcache_req_o.data_req;
    obs_idle = idle_o;
    obs_gidx = grant_idx_o;
    for (int i = 0; i < NUM_REQ; i++) begin
      obs_gnt[i] = req_port_o[i].data_gnt;
      obs_rv[i]  = req_port_o[i].data_rvalid;
      obs_rd[i]  = req_port_o[i].data_rdata;
    end
    if (chk) begin
      exp_req = '0;
      if (p >= 0) exp_req = req_port_i[p];
      check_eq("dcache_req", 160'(dcache_req_o), 160'(exp_req));
      check_eq("grant_idx", 160'(grant_idx_o), 160'((p >= 0) ? p : 0));
      check_eq("idle", 160'(idle_o), 160'((owner < 0) && (p < 0)));
      for (int i = 0; i < NUM_REQ; i++) begin
        check_eq($sformatf("gnt%0d", i), 160'(obs_gnt[i]), 160'(d_gnt && (p >= 0) && (p == i)));
        check_eq($sformatf("rvalid%0d", i), 160'(obs_rv[i]), 160'(d_rvalid && (last == i)));
        check_eq($sformatf("rdata%0d", i), 160'(obs_rd[i]), 160'((last == i) ? d_rdata : 64'h0));
      end
    end
    @(posedge clk_i);
    if (d_rst) begin
      owner = -1;
      ptr   = 0;
      last  = 0;
    end else if (d_gnt && (p >= 0)) begin
      owner = -1;
      ptr   = (p + 1) % NUM_REQ;
      last  = p;
      if (hold_all) pl[p] = rnd_pl();
      else rq[p] = 1'b0;
    end else if (p >= 0) begin
      owner = p;
    end
  endtask

  // a presented but ungranted requester must still be requesting one cycle later
  logic h_pend = 1'b0;
  int   h_idx  = 0;
  always @(posedge clk_i) begin
    if (h_pend && !rst_i) check_eq("hold_req", 160'(req_port_i[h_idx].data_req), 160'(1));
    h_pend <= dcache_req_o.data_req && !dcache_req_i.data_gnt && !rst_i;
    h_idx  <= int'(grant_idx_o);
  end

  initial begin
    rst_i = 1'b1;
    block_i = 1'b0;
    dcache_req_i = '0;
    hold_all = 1'b0;
    d_gnt = 1'b0;
    d_block = 1'b0;
    d_rvalid = 1'b0;
    d_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i] = 1'b0;
      pl[i] = rnd_pl();
      req_port_i[i] = '0;
    end

    // reset with req0 pending, then req0 presented at once
    d_rst = 1'b1;
    rq[0] = 1'b1;
    step(1'b0);
    step(1'b1);
    check_eq("rst_dreq", 160'(obs_dreq), 160'(0));
    check_eq("rst_idle", 160'(obs_idle), 160'(1));
    d_rst = 1'b0;
    step(1'b1);
    check_eq("first_dreq", 160'(obs_dreq), 160'(1));
    check_eq("first_gidx", 160'(obs_gidx), 160'(0));

    // lock on 0 while req1 rises; grant in cycle 4, req1 in cycle 5
    rq[1] = 1'b1;
    step(1'b1);
    check_eq("lock_gidx_c2", 160'(obs_gidx), 160'(0));
    step(1'b1);
    check_eq("lock_gidx_c3", 160'(obs_gidx), 160'(0));
    d_gnt = 1'b1;
    step(1'b1);
    check_eq("lock_gnt0", 160'(obs_gnt[0]), 160'(1));
    check_eq("lock_gnt1", 160'(obs_gnt[1]), 160'(0));
    d_gnt = 1'b0;
    step(1'b1);
    check_eq("next_gidx", 160'(obs_gidx), 160'(1));
    check_eq("next_dreq", 160'(obs_dreq), 160'(1));
    d_gnt = 1'b1;
    step(1'b1);

    // response two cycles after the grant to 1
    d_gnt = 1'b0;
    step(1'b1);
    d_rvalid = 1'b1;
    d_rdata  = 64'hDEAD_BEEF;
    step(1'b1);
    check_eq("rsp_rv1", 160'(obs_rv[1]), 160'(1));
    check_eq("rsp_rd1", 160'(obs_rd[1]), 160'(64'hDEAD_BEEF));
    check_eq("rsp_rv0", 160'(obs_rv[0]), 160'(0));
    check_eq("rsp_rv2", 160'(obs_rv[2]), 160'(0));
    check_eq("rsp_rd2", 160'(obs_rd[2]), 160'(0));
    d_rvalid = 1'b0;

    // fairness with everything requesting and the D$ always granting
    d_rst = 1'b1;
    step(1'b1);
    d_rst = 1'b0;
    hold_all = 1'b1;
    d_gnt = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
`ifdef STORE_ARB_FIXED_PRIO_EN
      check_eq($sformatf("order%0d", k), 160'(obs_gidx), 160'(0));
`else
      check_eq($sformatf("order%0d", k), 160'(obs_gidx), 160'(k % 3));
`endif
    end

    // block raised while locked on 1
    d_rst = 1'b1;
    step(1'b1);
    d_rst = 1'b0;
    hold_all = 1'b0;
    d_gnt = 1'b0;
    rq[0] = 1'b0;
    rq[1] = 1'b1;
    rq[2] = 1'b0;
    step(1'b1);
    check_eq("blk_lock_gidx", 160'(obs_gidx), 160'(1));
    rq[0] = 1'b1;
    rq[2] = 1'b1;
    d_block = 1'b1;
    step(1'b1);
    check_eq("blk_held_gidx", 160'(obs_gidx), 160'(1));
    d_gnt = 1'b1;
    step(1'b1);
    check_eq("blk_done_gnt1", 160'(obs_gnt[1]), 160'(1));
    for (int k = 0; k < 2; k++) begin
      step(1'b1);
      check_eq("blk_idle", 160'(obs_idle), 160'(1));
      check_eq("blk_dreq", 160'(obs_dreq), 160'(0));
    end
    d_block = 1'b0;
    step(1'b1);
    check_eq("unblk_dreq", 160'(obs_dreq), 160'(1));
`ifdef STORE_ARB_FIXED_PRIO_EN
    check_eq("unblk_gidx", 160'(obs_gidx), 160'(0));
`else
    check_eq("unblk_gidx", 160'(obs_gidx), 160'(2));
`endif

    // randomized traffic with occasional block and reset
    repeat (3000) begin
      d_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) d_block = !d_block;
      d_gnt    = 1'($urandom_range(0, 1));
      d_rvalid = !d_rst && ($urandom_range(0, 2) == 0);
      d_rdata  = {$urandom, $urandom};
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rq[i] && ($urandom_range(0, 2) == 0)) begin
          pl[i] = rnd_pl();
          rq[i] = 1'b1;
        end
      end
      step(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
